// File: rtl/add24_operand_stage.sv
// add24_operand_stage
// Two-entry skid buffer that registers operand sets (a, b, cin) in front of a
// 24-bit ripple-carry adder. It uses a valid/ready handshake on both sides.
// The main register drives the adder. The skid register catches one extra set
// when the adder stalls, because in_ready is registered and lags one cycle.
// A saturating counter tracks completed output transfers.
//
// Optional feature: define ADD24_OPERAND_STAGE_SUB_EN to add an in_sub port.
// When in_sub is set, the stage stores ~in_b with carry-in forced to 1, so the
// adder computes A-B.
module add24_operand_stage #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADD24_OPERAND_STAGE_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_in_ready;

    logic [WIDTH-1:0]   r_main_a;
    logic [WIDTH-1:0]   r_main_b;
    logic               r_main_cin;
    logic [WIDTH-1:0]   r_skid_a;
    logic [WIDTH-1:0]   r_skid_b;
    logic               r_skid_cin;
    logic [CNT_W-1:0]   r_xfer_cnt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_out_valid;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;

    // Operand B and carry-in as they will be stored.
    // In subtract mode, B is inverted and carry-in is forced to 1 (two's complement).
`ifdef ADD24_OPERAND_STAGE_SUB_EN
    assign w_b_in   = in_sub ? ~in_b : in_b;
    assign w_cin_in = in_sub | in_cin;
`else
    assign w_b_in   = in_b;
    assign w_cin_in = in_cin;
`endif

    // out_valid is decoded purely from the state register, so no input reaches an output.
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // Next-state and register-load decode for the skid buffer.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_in_fire, w_out_fire})
                    2'b10: begin
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end
                    2'b01: begin
                        w_state_next = ST_EMPTY;
                    end
                    2'b11: begin
                        w_state_next   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                    default: begin
                        w_state_next = ST_ONE;
                    end
                endcase
            end
            ST_FULL: begin
                // in_ready is low here, so any in_valid is simply ignored.
                if (w_out_fire) begin
                    w_state_next     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State register and registered in_ready.
    // in_ready is precomputed from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    // Main register: loads from the input port, or from the skid register when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_a   <= '0;
            r_main_b   <= '0;
            r_main_cin <= 1'b0;
        end else if (w_load_main_in) begin
            r_main_a   <= in_a;
            r_main_b   <= w_b_in;
            r_main_cin <= w_cin_in;
        end else if (w_load_main_skid) begin
            r_main_a   <= r_skid_a;
            r_main_b   <= r_skid_b;
            r_main_cin <= r_skid_cin;
        end
    end

    // Skid register: captures the set that arrives while the main register is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_cin <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_a   <= in_a;
            r_skid_b   <= w_b_in;
            r_skid_cin <= w_cin_in;
        end
    end

    // Saturating count of completed output transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_out_fire && (r_xfer_cnt != {CNT_W{1'b1}})) begin
            r_xfer_cnt <= r_xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_a     = r_main_a;
    assign out_b     = r_main_b;
    assign out_cin   = r_main_cin;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_add24_operand_stage.sv
// Directed testbench for add24_operand_stage.
// It uses a default instance (CNT_W=16) and a second instance with CNT_W=4 on the
// same inputs, which is used for the counter-saturation scenario.
// Inputs are driven and outputs are sampled on the falling edge of clk.
module tb_add24_operand_stage;

    localparam int WIDTH = 24;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_ready;
`ifdef ADD24_OPERAND_STAGE_SUB_EN
    logic             in_sub;
`endif

    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_cin;
    logic [15:0]      xfer_cnt;

    logic             in_ready4;
    logic             out_valid4;
    logic [WIDTH-1:0] out_a4;
    logic [WIDTH-1:0] out_b4;
    logic             out_cin4;
    logic [3:0]       xfer_cnt4;

    int n_checks;
    int n_fail;

    add24_operand_stage #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD24_OPERAND_STAGE_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_cin   (out_cin),
        .xfer_cnt  (xfer_cnt)
    );

    add24_operand_stage #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD24_OPERAND_STAGE_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_a     (out_a4),
        .out_b     (out_b4),
        .out_cin   (out_cin4),
        .xfer_cnt  (xfer_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // Reset values, and no transfer accepted on an edge while rst_n is low.
    task automatic test_reset();
        in_valid  = 1'b1;
        in_a      = 24'h000055;
        in_b      = 24'h0000AA;
        in_cin    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if ({out_a, out_b, out_cin} !== {24'h0, 24'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_data got a=%h b=%h cin=%b want zeros", out_a, out_b, out_cin);
        end
        n_checks++;
        if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept got out_valid=%b want 0", out_valid); end
        $display("test_reset done");
    endtask

    // A single set passes through with one cycle of latency.
    task automatic test_single();
        in_valid  = 1'b1;
        in_a      = 24'h000001;
        in_b      = 24'h000002;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_a, out_b, out_cin} !== {1'b1, 24'h000001, 24'h000002, 1'b0}) begin
            n_fail++;
            $display("FAIL single_out got v=%b a=%h b=%h cin=%b want v=1 a=000001 b=000002 cin=0",
                     out_valid, out_a, out_b, out_cin);
        end
        n_checks++;
        if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt_before got %0d want 0", xfer_cnt); end
        $display("xfer single a=%h b=%h cin=%b", out_a, out_b, out_cin);
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", xfer_cnt); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got out_valid=%b want 0", out_valid); end
    endtask

    // Backpressure: the stage fills, in_ready drops, then sets drain in FIFO order.
    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 24'h000010; in_b = 24'h000110; in_cin = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
        n_checks++;
        if (out_a !== 24'h000010) begin n_fail++; $display("FAIL bp_head1 got %h want 000010", out_a); end
        in_a = 24'h000020; in_b = 24'h000120; in_cin = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2 got %b want 0", in_ready); end
        n_checks++;
        if ({out_valid, out_a, out_b} !== {1'b1, 24'h000010, 24'h000110}) begin
            n_fail++; $display("FAIL bp_hold1 got v=%b a=%h b=%h want v=1 a=000010 b=000110", out_valid, out_a, out_b);
        end
        in_a = 24'h000030; in_b = 24'h000130; in_cin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_a, out_b, out_cin} !== {1'b0, 24'h000010, 24'h000110, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold2 got rdy=%b a=%h b=%h cin=%b want rdy=0 a=000010 b=000110 cin=0",
                               in_ready, out_a, out_b, out_cin);
        end
        $display("xfer bp a=%h", out_a);
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_a, out_b, out_cin} !== {1'b1, 1'b1, 24'h000020, 24'h000120, 1'b1}) begin
            n_fail++; $display("FAIL bp_second got rdy=%b v=%b a=%h b=%h cin=%b want rdy=1 v=1 a=000020 b=000120 cin=1",
                               in_ready, out_valid, out_a, out_b, out_cin);
        end
        $display("xfer bp a=%h", out_a);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_a, out_b} !== {1'b1, 24'h000030, 24'h000130}) begin
            n_fail++; $display("FAIL bp_third got v=%b a=%h b=%h want v=1 a=000030 b=000130", out_valid, out_a, out_b);
        end
        $display("xfer bp a=%h", out_a);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got out_valid=%b want 0", out_valid); end
        n_checks++;
        if (xfer_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_cnt got %0d want 3", xfer_cnt); end
    endtask

    // Streaming: one transfer per cycle for 100 cycles.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                exp_a = 24'h000100 + WIDTH'(i - 1);
                exp_b = WIDTH'((i - 1) * 3);
                n_checks++;
                if ({out_valid, in_ready, out_a, out_b} !== {1'b1, 1'b1, exp_a, exp_b}) begin
                    n_fail++; $display("FAIL b2b_%0d got v=%b rdy=%b a=%h b=%h want v=1 rdy=1 a=%h b=%h",
                                       i - 1, out_valid, in_ready, out_a, out_b, exp_a, exp_b);
                end
                $display("xfer b2b idx=%0d a=%h b=%h", i - 1, out_a, out_b);
            end
            in_valid = 1'b1;
            in_a     = 24'h000100 + WIDTH'(i);
            in_b     = WIDTH'(i * 3);
            in_cin   = i[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_a, out_cin} !== {1'b1, 24'h000163, 1'b1}) begin
            n_fail++; $display("FAIL b2b_last got v=%b a=%h cin=%b want v=1 a=000163 cin=1", out_valid, out_a, out_cin);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid); end
        n_checks++;
        if (xfer_cnt !== 16'd100) begin n_fail++; $display("FAIL b2b_cnt got %0d want 100", xfer_cnt); end
    endtask

    // Asynchronous reset while FULL discards both entries immediately.
    task automatic test_reset_full();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 24'h0000A1; in_b = 24'h0000B1; in_cin = 1'b1;
        @(negedge clk);
        in_a = 24'h0000A2; in_b = 24'h0000B2;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_fail++; $display("FAIL rf_full got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_a, out_b, out_cin} !== {1'b1, 1'b0, 24'h0, 24'h0, 1'b0}) begin
            n_fail++; $display("FAIL rf_async got rdy=%b v=%b a=%h b=%h cin=%b want rdy=1 v=0 zeros",
                               in_ready, out_valid, out_a, out_b, out_cin);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_stale_%0d got out_valid=%b want 0", i, out_valid); end
        end
        n_checks++;
        if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rf_cnt got %0d want 0", xfer_cnt); end
        $display("test_reset_full done");
    endtask

    // Counter saturation with CNT_W=4: 20 transfers leave it at F, and it stays there.
    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = WIDTH'(i); in_b = 24'h0; in_cin = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (xfer_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_cnt4 got %h want f", xfer_cnt4); end
        n_checks++;
        if (xfer_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16 got %0d want 20", xfer_cnt); end
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL sat_drain4 got out_valid=%b want 0", out_valid4); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = WIDTH'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (xfer_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_hold4 got %h want f", xfer_cnt4); end
        n_checks++;
        if (xfer_cnt !== 16'd23) begin n_fail++; $display("FAIL sat_cnt16_more got %0d want 23", xfer_cnt); end
        $display("test_saturate cnt4=%h cnt16=%0d", xfer_cnt4, xfer_cnt);
    endtask

`ifdef ADD24_OPERAND_STAGE_SUB_EN
    // Subtract mode: 5 - 3 through the adder gives sum 2 with carry-out 1.
    task automatic test_sub();
        logic [WIDTH:0] sum;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sub    = 1'b1;
        in_a = 24'h000005; in_b = 24'h000003; in_cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_sub   = 1'b0;
        n_checks++;
        if ({out_b, out_cin} !== {24'hFFFFFC, 1'b1}) begin
            n_fail++; $display("FAIL sub_ops got b=%h cin=%b want b=fffffc cin=1", out_b, out_cin);
        end
        sum = {1'b0, out_a} + {1'b0, out_b} + {{WIDTH{1'b0}}, out_cin};
        n_checks++;
        if (sum !== 25'h1000002) begin n_fail++; $display("FAIL sub_sum got %h want 1000002", sum); end
        $display("xfer sub a=%h b=%h cin=%b", out_a, out_b, out_cin);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef ADD24_OPERAND_STAGE_SUB_EN
        in_sub    = 1'b0;
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_full();
        test_saturate();
`ifdef ADD24_OPERAND_STAGE_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
